cla_pipelined_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the fixed 16-bit cascaded 4-bit CLA.
//  - Operand width, lookahead group size and pipeline depth are set by parameters.
//  - Pipeline registers sit between group blocks, and a valid/ready handshake provides backpressure.
//  - Sits in the datapath as the ALU add/sub unit: one operation accepted per clock, results returned in order.

---
 rtl/cla_pipelined_adder_if.sv | 38 +++
 rtl/cla_pipelined_adder.sv | 144 ++++++++++++++
 tb/tb_cla_pipelined_adder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipelined_adder_if.sv
// Operation/result bus of the pipelined CLA adder/subtractor.
// The ovf signal exists only when CLA_OVF_FLAG_EN is defined.
interface cla_pipelined_adder_if #(
  parameter int WIDTH = 32
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds its payload stable while valid && !ready; ready may
  // depend combinationally on the consumer side but never on valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef CLA_OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef CLA_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef CLA_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor, S = GROUP*STAGE_GROUPS bits per stage.
// Optional signed-overflow flag enabled by defining CLA_OVF_FLAG_EN.
module cla_pipelined_adder #(
  parameter int WIDTH        = 32,
  parameter int GROUP        = 4,
  parameter int STAGE_GROUPS = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  cla_pipelined_adder_if.slave bus
);
  localparam int S      = GROUP * STAGE_GROUPS;
  localparam int NSTAGE = WIDTH / S;

  if (WIDTH % S != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of GROUP*STAGE_GROUPS");
  end

  // One stage worth of bits: lookahead inside each group, group carry ripples.
  function automatic logic [S:0] stage_add(input logic [S-1:0] x,
                                           input logic [S-1:0] y,
                                           input logic         ci);
    logic [S-1:0]     s;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             gc;
    logic             t;
    logic             pp;
    s  = '0;
    g  = '0;
    p  = '0;
    c  = '0;
    t  = 1'b0;
    pp = 1'b0;
    gc = ci;
    for (int gi = 0; gi < STAGE_GROUPS; gi++) begin
      g    = x[gi*GROUP +: GROUP] & y[gi*GROUP +: GROUP];
      p    = x[gi*GROUP +: GROUP] ^ y[gi*GROUP +: GROUP];
      c[0] = gc;
      for (int i = 0; i < GROUP; i++) begin
        t  = g[i];
        pp = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          t  = t | (pp & g[j]);
          pp = pp & p[j];
        end
        c[i+1] = t | (pp & gc);
      end
      s[gi*GROUP +: GROUP] = p ^ c[GROUP-1:0];
      gc = c[GROUP];
    end
    return {gc, s};
  endfunction

  logic out_valid;
  logic advance;

  assign out_valid     = stg[NSTAGE-1].v_q;
  assign advance       = !out_valid || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid;
  assign bus.sum       = stg[NSTAGE-1].s_q;
  assign bus.c_out     = stg[NSTAGE-1].c_q;

  for (genvar k = 0; k < NSTAGE; k++) begin : stg
    // Operand bits still to be added at this stage's input, LSB-aligned.
    localparam int RW = WIDTH - k * S;

    logic                 v_src;
    logic                 c_src;
    logic [RW-1:0]        a_src;
    logic [RW-1:0]        b_src;
    logic [S:0]           r;
    logic                 v_q;
    logic                 c_q;
    logic [(k+1)*S-1:0]   s_q;
    logic [(k+1)*S-1:0]   s_d;

    if (k == 0) begin : g_src
      assign v_src = bus.in_valid;
      assign a_src = bus.a;
      assign b_src = bus.sub ? ~bus.b : bus.b;
      assign c_src = bus.sub | bus.c_in;
      assign s_d   = r[S-1:0];
    end else begin : g_src
      assign v_src = stg[k-1].v_q;
      assign a_src = stg[k-1].g_opr.a_q;
      assign b_src = stg[k-1].g_opr.b_q;
      assign c_src = stg[k-1].c_q;
      assign s_d   = {r[S-1:0], stg[k-1].s_q};
    end

    assign r = stage_add(a_src[S-1:0], b_src[S-1:0], c_src);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (advance) begin
        v_q <= v_src;
        if (v_src) begin
          s_q <= s_d;
          c_q <= r[S];
        end
      end
    end

    if (k < NSTAGE - 1) begin : g_opr
      logic [RW-S-1:0] a_q;
      logic [RW-S-1:0] b_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_src) begin
          a_q <= a_src[RW-1:S];
          b_q <= b_src[RW-1:S];
        end
      end
    end
  end

`ifdef CLA_OVF_FLAG_EN
  // Sign bits are the top bits of what the final stage consumes.
  logic a_msb;
  logic b_msb;
  logic s_msb;
  logic ovf_q;
  assign a_msb = stg[NSTAGE-1].a_src[S-1];
  assign b_msb = stg[NSTAGE-1].b_src[S-1];
  assign s_msb = stg[NSTAGE-1].r[S-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance && stg[NSTAGE-1].v_src) begin
      ovf_q <= (a_msb == b_msb) && (s_msb != a_msb);
    end
  end
  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Randomized self-checking bench for cla_pipelined_adder (default 32/4/2, latency 4).
module tb_cla_pipelined_adder;
  localparam int W = 32;
  typedef logic [W+1:0] res_t;  // {ovf, c_out, sum}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_pipelined_adder_if #(.WIDTH(W)) bus ();

  cla_pipelined_adder #(.WIDTH(W), .GROUP(4), .STAGE_GROUPS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_emit   = 0;
  int   ov_cnt   = 0;
  int   run      = 0;
  int   max_run  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] s;
    logic         c;
    logic         v;
    longint       sr;
    longint       lim;
    lim = longint'(1) << (W - 1);
    if (sub) begin
      s  = a - b;
      c  = (a >= b);
      sr = longint'($signed(a)) - longint'($signed(b));
    end else begin
      {c, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      sr = longint'($signed(a)) + longint'($signed(b)) + longint'({63'd0, cin});
    end
    v = (sr >= lim) || (sr < -lim);
    return {v, c, s};
  endfunction

  function automatic res_t observed();
`ifdef CLA_OVF_FLAG_EN
    return {bus.ovf, bus.c_out, bus.sum};
`else
    return {1'b0, bus.c_out, bus.sum};
`endif
  endfunction

  function automatic res_t masked(input res_t e);
    res_t m;
    m = e;
`ifndef CLA_OVF_FLAG_EN
    m[W+1] = 1'b0;
`endif
    return m;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    case ($urandom_range(0, 5))
      0: w = '0;
      1: w = '1;
      2: w = {1'b0, {(W-1){1'b1}}};
      3: w = {1'b1, {(W-1){1'b0}}};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  initial begin
    logic         stall_prev;
    res_t         held;
    res_t         e;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_hold", 64'(observed()), 64'(held));
      end
      if (bus.out_valid) begin
        ov_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (!rst_n) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          n_emit++;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(observed()), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("result", 64'(observed()), 64'(masked(e)));
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
        stall_prev = bus.out_valid && !bus.out_ready;
        held = observed();
      end
    end
  end

  // Driver tasks are entered and left just after a rising edge.
  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = cin;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept(output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.c_in     = 1'($urandom_range(0, 1));
    bus.sub      = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, output int waited);
    set_op(a, b, cin, sub);
    wait_accept(waited);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t < 100), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [W-1:0] s, input logic c, input logic v,
                            output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.out_valid && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("out_valid", 64'(bus.out_valid), 64'(1));
    check("sum", 64'(bus.sum), 64'(s));
    check("c_out", 64'(bus.c_out), 64'(c));
`ifdef CLA_OVF_FLAG_EN
    check("ovf", 64'(bus.ovf), 64'(v));
`else
    if (v) waited = waited + 0;
`endif
  endtask

  initial begin
    int w;
    int base;
    logic acc;
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    logic acc;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_c_out", 64'(bus.c_out), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef CLA_OVF_FLAG_EN
    check("rst_ovf", 64'(bus.ovf), 64'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Wrap-around with exact latency of 4.
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, w);
    repeat (3) begin
      @(negedge clk);
      check("latency_early", 64'(bus.out_valid), 64'(0));
    end
    expect_out(32'h0, 1'b1, 1'b0, w);
    check("latency_4", 64'(w), 64'(0));
    wait_drain();

    // Subtraction with borrow, c_in ignored.
    send(32'h5, 32'h7, 1'b1, 1'b1, w);
    expect_out(32'hFFFF_FFFE, 1'b0, 1'b0, w);
    wait_drain();

    // Signed overflow, add and subtract.
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, w);
    expect_out(32'h8000_0000, 1'b0, 1'b1, w);
    wait_drain();
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1, w);
    expect_out(32'h7FFF_FFFF, 1'b1, 1'b1, w);
    wait_drain();

    // Eight back-to-back random ops.
    ov_cnt  = 0;
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      check("b2b_in_ready", 64'(w), 64'(0));
    end
    wait_drain();
    check("b2b_count", 64'(ov_cnt), 64'(8));
    check("b2b_consecutive", 64'(max_run), 64'(8));

    // Fill, stall 5 cycles, then drain.
    base = n_emit;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
    set_op(rand_word(), rand_word(), 1'b1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept(w);
    wait_drain();
    check("stall_emit_count", 64'(n_emit - base), 64'(5));

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++)
      send($urandom, $urandom, 1'b0, 1'b0, w);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_stale", 64'(bus.out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, w);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_early", 64'(bus.out_valid), 64'(0));
    end
    expect_out(32'h2345_678A, 1'b0, 1'b0, w);
    check("post_rst_latency", 64'(w), 64'(0));
    wait_drain();

    // Random traffic with random backpressure and bubbles.
    acc = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a        = rand_word();
        bus.b        = rand_word();
        bus.c_in     = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
